// File: rtl/sequential_adder.sv
// sequential_adder: multi-cycle adder/subtractor that processes K bits per
// clock over N/K cycles, with valid/ready handshakes on input and output.
module sequential_adder #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow
);

    generate
        if (K < 1) begin : g_bad_k
            $error("sequential_adder: K must be >= 1");
        end else if ((N % K) != 0) begin : g_bad_nk
            $error("sequential_adder: N must be a multiple of K");
        end
    endgenerate

    localparam int CHUNKS = N / K;
    localparam int IDXW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;      // already inverted for subtraction
    logic            carry;
    logic [IDXW-1:0] idx;

    logic [K-1:0]    chunk_a;
    logic [K-1:0]    chunk_b;
    logic [K-1:0]    chunk_sum;
    logic            chunk_co;
    logic            chunk_msb_ci;
    logic            last_chunk;

    // Current chunk slice of the latched operands and its K-bit ripple sum.
    always_comb begin
        chunk_a = op_a[idx*K +: K];
        chunk_b = op_b[idx*K +: K];
        {chunk_co, chunk_sum} = {1'b0, chunk_a} + {1'b0, chunk_b} + {{K{1'b0}}, carry};
        // Carry into the chunk MSB recovered from the MSB sum bit.
        chunk_msb_ci = chunk_a[K-1] ^ chunk_b[K-1] ^ chunk_sum[K-1];
        last_chunk   = (idx == LAST_IDX);
    end

    // State register; reset overrides any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        i_ready   = 1'b0;
        o_valid   = 1'b0;
        case (state)
            IDLE: begin
                i_ready = 1'b1;
                if (i_valid) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last_chunk) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (o_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-chunk accumulation and final flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        // Subtraction as a + ~b + ~borrow_in.
                        op_a  <= a;
                        op_b  <= b ^ {N{sub}};
                        carry <= c_in ^ sub;
                        idx   <= '0;
                    end
                end
                BUSY: begin
                    sum[idx*K +: K] <= chunk_sum;
                    carry           <= chunk_co;
                    if (last_chunk) begin
                        idx      <= '0;
                        c_out    <= chunk_co;
                        overflow <= chunk_msb_ci ^ chunk_co;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sequential_adder.md
SEQUENTIAL_ADDER -- requirements
Module: sequential_adder

Interface
REQ-001 The block SHALL have parameter N, default 8, operand width in bits.
REQ-002 The block SHALL have parameter K, default 4, bits added per cycle; N % K == 0 and K >= 1 are required, violations SHALL fail elaboration.
REQ-003 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port i_valid  input  1  operands and mode present.
REQ-006 Port i_ready  output  1  block accepts a new operation.
REQ-007 Port a  input  N  operand A.
REQ-008 Port b  input  N  operand B.
REQ-009 Port c_in  input  1  carry-in (add) / borrow-in (subtract).
REQ-010 Port sub  input  1  0 = a+b+c_in; 1 = a-b-c_in.
REQ-011 Port o_valid  output  1  result valid.
REQ-012 Port o_ready  input  1  consumer accepts result.
REQ-013 Port sum  output  N  result, two's-complement wrap modulo 2^N.
REQ-014 Port c_out  output  1  carry out of bit N-1 of the internal adder (sub mode: 1 = no borrow).
REQ-015 Port overflow  output  1  signed overflow: carry into bit N-1 XOR carry out of bit N-1.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, BUSY and DONE.
REQ-017 In IDLE: i_ready=1, o_valid=0; on i_valid=1 at an edge, latch a, b XOR {N{sub}}, initial carry = c_in XOR sub, clear chunk index, go to BUSY.
REQ-018 In BUSY: each cycle add chunk idx (bits idx*K+K-1 : idx*K) of the latched operands plus the carry register, write the K result bits into sum, update the carry register, increment idx.
REQ-019 After chunk N/K-1 the FSM SHALL go to DONE, capture c_out and overflow from the final chunk and reset idx to 0.
REQ-020 Latency: if accepted at edge T, o_valid SHALL be 1 after edge T+N/K; K=N gives 1-cycle latency.
REQ-021 In DONE: o_valid=1; sum, c_out and overflow SHALL be held stable until an edge with o_ready=1, then go to IDLE.
REQ-022 i_ready SHALL be 0 in BUSY and DONE; i_valid and operand changes there SHALL be ignored, with no queuing.
REQ-023 A new operation SHALL NOT be accepted in the same cycle a result is consumed; minimum initiation interval = N/K+2 cycles.
REQ-024 Operands SHALL be sampled only at the accept edge; later changes to a, b, c_in or sub SHALL NOT affect the in-flight result.
REQ-025 sum SHALL hold its last completed value in IDLE; partial sum bits in BUSY are not architecturally valid.

Reset
REQ-026 On rst=1 at an edge, from any state including mid-BUSY or DONE, the FSM SHALL go to IDLE with sum=0, c_out=0, overflow=0, o_valid=0, carry register=0, idx=0, and i_ready=1 on the following cycle.
REQ-027 rst SHALL take priority over i_valid and o_ready in the same cycle; an operation presented during reset SHALL be dropped.

Verification
REQ-028 N=8, K=4, add: a=0xFF, b=0x01, c_in=0, o_ready=1 -> o_valid 2 cycles after accept, sum=0x00, c_out=1, overflow=0.
REQ-029 N=8, K=4, add: a=0x7F, b=0x01, c_in=0 -> sum=0x80, c_out=0, overflow=1; sub: a=0x05, b=0x07, c_in=0 -> sum=0xFE, c_out=0, overflow=0; sub: a=0x80, b=0x01, c_in=0 -> sum=0x7F, c_out=1, overflow=1.
REQ-030 Backpressure: hold o_ready=0 for 3 cycles in DONE while toggling i_valid and operands -> o_valid, sum, c_out and overflow stay constant, i_ready=0, and exactly one result is delivered when o_ready=1.
REQ-031 Reset mid-operation: assert rst for 1 cycle during BUSY chunk 1 of 0x12+0x34 -> next cycle IDLE, all outputs 0, i_ready=1; then 0x0F+0x01 completes with sum=0x10.
REQ-032 Exhaustive: N=4 with K in {1,2,4}, all 2^10 combinations of a, b, c_in and sub -> sum, c_out and overflow equal a golden model, and latency = N/K every time.
